iotdf_param: RTL and testbench
==============================

# iotdf_param

Parametrised IoT data filter that assembles fixed-width datasets from narrow input beats and applies one of seven selectable functions per group of datasets: max, min, average, range extract, range exclude, peak-max and peak-min. It sits between the sensor-byte ingress and the result bus. It is the generalised successor to the fixed 128-bit/8-bit/8-dataset filter, with:
- configurable widths and group size
- runtime range bounds
- a real `busy` handshake
- defined behaviour on function change

## Interface
- `DATA_W`, 128: dataset width in bits; multiple of `BEAT_W`.
- `BEAT_W`, 8: input beat width; beats per dataset `N = DATA_W/BEAT_W` (≥2).
- `GROUP`, 8: datasets per group; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_en` input 1: beat valid.
- `iot_in` input `BEAT_W`: beat data, MSB beat of a dataset first.
- `fn_sel` input 3: 1 max, 2 min, 3 avg, 4 extract, 5 exclude, 6 peak-max, 7 peak-min; 0 reserved (beats accepted, no output).
- `lo_bound` input `DATA_W`: lower range bound (unsigned).
- `hi_bound` input `DATA_W`: upper range bound (unsigned).
- `busy` output 1: beats not accepted this cycle.
- `valid` output 1: one-cycle result strobe.
- `iot_out` output `DATA_W`: result; holds its value between strobes.

## Operation
- A beat is accepted when `in_en=1` and `busy=0`. Beats presented while `busy=1` are dropped.
- The beat counter runs 0..N-1 and wraps. The dataset counter runs 0..`GROUP`-1 and wraps at the last beat of each dataset.
- `fn_sel` is sampled on beat 0 of every dataset. Changes mid-dataset are ignored until the next beat 0.
- If the sampled `fn_sel` differs from the previous dataset's, the following are cleared and that dataset becomes dataset 0 of a new group:
  - group accumulator
  - dataset counter
  - peak register and its valid flag
- All comparisons are unsigned over the full `DATA_W`.
- Max/min: running extreme over the group. The result is output after the last dataset of the group.
- Avg: sum register of width `DATA_W+log2(GROUP)`, no overflow. Result = sum >> `log2(GROUP)`, truncated.
- Extract: per dataset, output the dataset if `lo_bound < data < hi_bound`.
- Exclude: per dataset, output the dataset if `data < lo_bound` or `data > hi_bound`.
- Peak-max/peak-min: compute the group extreme as for max/min.
  - The first group after reset or a function change always outputs and loads the peak.
  - Later groups output and update the peak only if the group extreme is strictly greater (peak-max) or strictly less (peak-min) than the peak.
- Bounds are sampled on the last beat of the dataset they apply to.
- Reserved `fn_sel` produces no `valid`.

## Timing
- Reset values: `valid=0`, `busy=0`, `iot_out=0`; all counters, accumulators and peak flags are cleared.
- `rst` asserted mid-dataset discards the partial dataset. The first accepted beat after release is beat 0.
- Latency: `valid` rises on the cycle after the accepting edge of the final beat, and is high for exactly one cycle.
- `busy` is high only during group-result cycles, i.e. the same cycle as a group-end `valid` for functions 1, 2, 3, 6 and 7. Extract and exclude never raise `busy`.
- `in_en` gaps of any length pause the counters with no loss of state.
- Back-to-back datasets are allowed at one beat per cycle, except for the single busy cycle after each group.

## Configuration
- `IOTDF_AVG_EN` defined: the average function is built, including the wide sum register.
- Not defined: function 3 behaves as reserved. Beats are accepted, no `valid` is produced, the sum register is absent and `busy` never asserts for fn 3.

## Structure
- Package `iotdf_pkg` holds:
  - function-select enum: `FN_NONE`, `FN_MAX`, `FN_MIN`, `FN_AVG`, `FN_EXT`, `FN_EXC`, `FN_PMAX`, `FN_PMIN`
  - a constant function for beats per dataset
  - a constant function for `log2(GROUP)`
- Sub-module `iotdf_collector` contains:
  - beat shift register to `DATA_W`
  - beat counter
  - `busy`-qualified accept
  - one-cycle `dataset_done` pulse with the assembled dataset

## Test plan
All scenarios use default parameters: 16 beats per dataset, groups of 8.
- **Max/min:** fn=1, datasets with low byte 1..8, others 0 → a single `valid` one cycle after beat 128 with `iot_out=128'h08`. Repeat with fn=2 → `128'h01`.
- **Avg:** fn=3, eight datasets of all-ones → `iot_out` all-ones. Values 1..8 → `128'h4` (36>>3). Rebuild without `IOTDF_AVG_EN` → no `valid`.
- **Extract/exclude bounds:** `lo_bound=0x10`, `hi_bound=0x20`, datasets 0x10, 0x15, 0x20, 0x30. Fn=4 → `valid` only for 0x15. Fn=5 → `valid` only for 0x30. Equality at either bound never qualifies.
- **Peak-max:** fn=6, group maxima 0x50, 0x40, 0x60 → `valid` with 0x50, none, then 0x60. Switch to fn=7 at the next dataset boundary → the next group always outputs.
- **Handshake:**
  - `in_en` low for 3 cycles mid-dataset → result unchanged versus the gap-free run.
  - A beat driven during `busy` → dropped, so the next dataset completes one beat later.
  - A `fn_sel` change at beat 7 → ignored until beat 0.
- **Reset:** `rst` low after 5 beats of a dataset → `valid=0` and `iot_out=0` immediately. After release, a full 8-dataset max group produces the correct result with no contribution from the 5 stale beats.

Source files
------------

// File: rtl/iotdf_pkg.sv
// Shared types and elaboration-time helpers for the iotdf filter.
package iotdf_pkg;

   typedef enum logic [2:0] {
      FN_NONE = 3'd0,
      FN_MAX  = 3'd1,
      FN_MIN  = 3'd2,
      FN_AVG  = 3'd3,
      FN_EXT  = 3'd4,
      FN_EXC  = 3'd5,
      FN_PMAX = 3'd6,
      FN_PMIN = 3'd7
   } fn_e;

   function automatic int beats_per_ds(input int data_w, input int beat_w);
      return data_w / beat_w;
   endfunction

   function automatic int grp_log2(input int group);
      int r;
      r = 0;
      while ((1 << r) < group) r++;
      return r;
   endfunction

endpackage

// File: rtl/iotdf_collector.sv
// Assembles DATA_W datasets from BEAT_W beats, MSB beat first; the dataset
// and its done strobe are presented combinationally on the final accepted beat.
module iotdf_collector
   import iotdf_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int BEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic              busy,
   input  logic [BEAT_W-1:0] iot_in,
   output logic              beat0,
   output logic              dataset_done,
   output logic [DATA_W-1:0] dataset
);
   localparam int N  = beats_per_ds(DATA_W, BEAT_W);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0]            cnt_q, cnt_d;
   logic [DATA_W-BEAT_W-1:0] sh_q, sh_d;
   logic                     accept, last;

   always_comb begin
      accept       = in_en && !busy;
      last         = (cnt_q == CW'(N - 1));
      beat0        = accept && (cnt_q == '0);
      dataset_done = accept && last;
      dataset      = {sh_q, iot_in};
      cnt_d        = cnt_q;
      sh_d         = sh_q;
      if (accept) begin
         cnt_d = last ? '0 : cnt_q + CW'(1);
         sh_d  = dataset[DATA_W-BEAT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/iotdf_param.sv
// Parametrised IoT data filter: max/min/avg/extract/exclude/peak-max/peak-min.
// Define IOTDF_AVG_EN to build the average function and its wide sum register.
module iotdf_param
   import iotdf_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int BEAT_W = 8,
   parameter int GROUP  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic [BEAT_W-1:0] iot_in,
   input  logic [2:0]        fn_sel,
   input  logic [DATA_W-1:0] lo_bound,
   input  logic [DATA_W-1:0] hi_bound,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] iot_out
);
   localparam int GW = grp_log2(GROUP);

   logic              beat0, ds_done;
   logic [DATA_W-1:0] ds;

   fn_e               fn_q, fn_d;
   logic [GW-1:0]     ds_cnt_q, ds_cnt_d;
   logic [DATA_W-1:0] ext_q, ext_d, pk_q, pk_d, out_q, out_d;
   logic              pkv_q, pkv_d, valid_q, valid_d, busy_q, busy_d;
   logic              first, gend;
   logic [DATA_W-1:0] gmax, gmin;
`ifdef IOTDF_AVG_EN
   logic [DATA_W+GW-1:0] sum_q, sum_d;
`endif

   iotdf_collector #(.DATA_W(DATA_W), .BEAT_W(BEAT_W)) u_coll (
      .clk          (clk),
      .rst          (rst),
      .in_en        (in_en),
      .busy         (busy_q),
      .iot_in       (iot_in),
      .beat0        (beat0),
      .dataset_done (ds_done),
      .dataset      (ds)
   );

   always_comb begin
      fn_d     = fn_q;
      ds_cnt_d = ds_cnt_q;
      ext_d    = ext_q;
      pk_d     = pk_q;
      pkv_d    = pkv_q;
      out_d    = out_q;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
`ifdef IOTDF_AVG_EN
      sum_d    = sum_q;
`endif
      first = (ds_cnt_q == '0);
      gend  = (ds_cnt_q == GW'(GROUP - 1));
      gmax  = (first || ds > ext_q) ? ds : ext_q;
      gmin  = (first || ds < ext_q) ? ds : ext_q;

      // A new function restarts the group and forgets any stored peak.
      if (beat0 && (fn_e'(fn_sel) != fn_q)) begin
         fn_d     = fn_e'(fn_sel);
         ds_cnt_d = '0;
         ext_d    = '0;
         pk_d     = '0;
         pkv_d    = 1'b0;
`ifdef IOTDF_AVG_EN
         sum_d    = '0;
`endif
      end

      if (ds_done) begin
         ds_cnt_d = gend ? '0 : ds_cnt_q + GW'(1);
         case (fn_q)
            FN_MAX: begin
               ext_d = gmax;
               if (gend) begin
                  valid_d = 1'b1; busy_d = 1'b1; out_d = gmax;
               end
            end
            FN_MIN: begin
               ext_d = gmin;
               if (gend) begin
                  valid_d = 1'b1; busy_d = 1'b1; out_d = gmin;
               end
            end
`ifdef IOTDF_AVG_EN
            FN_AVG: begin
               sum_d = (first ? '0 : sum_q) + {{GW{1'b0}}, ds};
               if (gend) begin
                  valid_d = 1'b1; busy_d = 1'b1; out_d = sum_d[DATA_W+GW-1:GW];
               end
            end
`endif
            FN_EXT: begin
               if (ds > lo_bound && ds < hi_bound) begin
                  valid_d = 1'b1; out_d = ds;
               end
            end
            FN_EXC: begin
               if (ds < lo_bound || ds > hi_bound) begin
                  valid_d = 1'b1; out_d = ds;
               end
            end
            FN_PMAX: begin
               ext_d = gmax;
               if (gend && (!pkv_q || gmax > pk_q)) begin
                  valid_d = 1'b1; busy_d = 1'b1; out_d = gmax;
                  pk_d = gmax; pkv_d = 1'b1;
               end
            end
            FN_PMIN: begin
               ext_d = gmin;
               if (gend && (!pkv_q || gmin < pk_q)) begin
                  valid_d = 1'b1; busy_d = 1'b1; out_d = gmin;
                  pk_d = gmin; pkv_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fn_q     <= FN_NONE;
         ds_cnt_q <= '0;
         ext_q    <= '0;
         pk_q     <= '0;
         pkv_q    <= 1'b0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef IOTDF_AVG_EN
         sum_q    <= '0;
`endif
      end else begin
         fn_q     <= fn_d;
         ds_cnt_q <= ds_cnt_d;
         ext_q    <= ext_d;
         pk_q     <= pk_d;
         pkv_q    <= pkv_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef IOTDF_AVG_EN
         sum_q    <= sum_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign valid   = valid_q;
   assign iot_out = out_q;

endmodule

// File: tb/tb_iotdf_param.sv
// Self-checking bench for iotdf_param against a dataset/group-level reference model.
`timescale 1ns/1ps
module tb_iotdf_param;
   localparam int DATA_W = 128;
   localparam int BEAT_W = 8;
   localparam int GROUP  = 8;
   localparam int N      = DATA_W / BEAT_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_en = 1'b0;
   logic [BEAT_W-1:0] iot_in = '0;
   logic [2:0]        fn_sel = '0;
   logic [DATA_W-1:0] lo_bound = '0;
   logic [DATA_W-1:0] hi_bound = '0;
   logic              busy, valid;
   logic [DATA_W-1:0] iot_out;

   int checks = 0;
   int errors = 0;
   int gap_pct = 0;
   int gap_at = -1;
   bit chk_en = 1'b0;

   // reference model state
   logic [DATA_W-1:0] m_cur, m_out, m_pk;
   int                m_nbeat, m_fn;
   bit                m_valid, m_busy, m_pkv, m_acc;
   logic [DATA_W-1:0] grp[$];
   logic [DATA_W-1:0] log_q[$];

   iotdf_param #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .GROUP(GROUP)) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
      .lo_bound(lo_bound), .hi_bound(hi_bound), .busy(busy), .valid(valid), .iot_out(iot_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", DATA_W'(valid), DATA_W'(m_valid));
         check("busy", DATA_W'(busy), DATA_W'(m_busy));
         check("iot_out", iot_out, m_out);
      end
   end

   task automatic model_reset();
      m_cur = '0; m_out = '0; m_pk = '0;
      m_nbeat = 0; m_fn = 0;
      m_valid = 0; m_busy = 0; m_pkv = 0; m_acc = 0;
      grp.delete();
   endtask

   task automatic emit(input logic [DATA_W-1:0] v, input bit group_result);
      m_valid = 1;
      m_out = v;
      if (group_result) m_busy = 1;
      log_q.push_back(v);
   endtask

   task automatic model_dataset(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] mx, mn;
      logic [DATA_W+3:0] s;
      if (m_fn == 4 && d > lo_bound && d < hi_bound) emit(d, 0);
      if (m_fn == 5 && (d < lo_bound || d > hi_bound)) emit(d, 0);
      grp.push_back(d);
      if (grp.size() == GROUP) begin
         mx = grp[0]; mn = grp[0]; s = '0;
         foreach (grp[i]) begin
            if (grp[i] > mx) mx = grp[i];
            if (grp[i] < mn) mn = grp[i];
            s = s + grp[i];
         end
         case (m_fn)
            1: emit(mx, 1);
            2: emit(mn, 1);
            3: begin
`ifdef IOTDF_AVG_EN
               emit(DATA_W'(s / GROUP), 1);
`endif
            end
            6: if (!m_pkv || mx > m_pk) begin m_pk = mx; m_pkv = 1; emit(mx, 1); end
            7: if (!m_pkv || mn < m_pk) begin m_pk = mn; m_pkv = 1; emit(mn, 1); end
            default: ;
         endcase
         grp.delete();
      end
   endtask

   task automatic model_edge();
      m_acc = in_en && !m_busy;
      m_valid = 0;
      m_busy = 0;
      if (m_acc) begin
         if (m_nbeat == 0 && int'(fn_sel) != m_fn) begin
            m_fn = int'(fn_sel);
            grp.delete();
            m_pkv = 0;
         end
         m_cur = (m_cur << BEAT_W) | DATA_W'(iot_in);
         m_nbeat++;
         if (m_nbeat == N) begin
            m_nbeat = 0;
            model_dataset(m_cur);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) model_edge();
      else m_acc = 0;
      @(negedge clk);
   endtask

   task automatic send_ds(input logic [DATA_W-1:0] d, input int fn, output int cyc);
      int b, tries;
      bit gapped;
      b = 0; tries = 0; cyc = 0; gapped = 0;
      while (b < N) begin
         tries++;
         if (tries > 8 * N) begin
            errors++;
            $display("FAIL send_timeout: dataset %h stuck at beat %0d", d, b);
            break;
         end
         if ((b == gap_at && !gapped) || (gap_pct != 0 && $urandom_range(0, 99) < gap_pct)) begin
            if (b == gap_at && !gapped) begin
               gapped = 1;
               in_en = 0;
               repeat (3) tick();
            end else begin
               in_en = 0;
               iot_in = BEAT_W'($urandom);
               tick();
            end
         end else begin
            in_en = 1;
            iot_in = d[DATA_W-1-b*BEAT_W -: BEAT_W];
            fn_sel = (b == 0) ? 3'(fn) : 3'($urandom_range(0, 7));
            tick();
            cyc++;
            if (m_acc) b++;
         end
      end
      in_en = 0;
   endtask

   task automatic send_ramp(input int fn, input logic [DATA_W-1:0] base, output int first_cyc);
      int c;
      for (int k = 0; k < GROUP; k++) begin
         send_ds(base + DATA_W'(k), fn, c);
         if (k == 0) first_cyc = c;
      end
   endtask

   task automatic chk_log1(input string nm, input logic [DATA_W-1:0] v);
      check({nm, "_count"}, DATA_W'(log_q.size()), DATA_W'(1));
      check({nm, "_value"}, (log_q.size() > 0) ? log_q[0] : 'x, v);
      log_q.delete();
   endtask

   task automatic chk_log0(input string nm);
      check({nm, "_count"}, DATA_W'(log_q.size()), DATA_W'(0));
      log_q.delete();
   endtask

   initial begin
      int c, c0;
      logic [DATA_W-1:0] d;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_valid", DATA_W'(valid), DATA_W'(0));
      check("reset_busy", DATA_W'(busy), DATA_W'(0));
      check("reset_out", iot_out, DATA_W'(0));
      chk_en = 1;
      rst = 1;
      tick();

      // max then min over datasets 1..8
      send_ramp(1, DATA_W'(1), c0);
      check("first_ds_cycles", DATA_W'(c0), DATA_W'(N));
      chk_log1("max", DATA_W'(8));
      send_ramp(2, DATA_W'(1), c0);
      check("beat_dropped_in_busy", DATA_W'(c0), DATA_W'(N + 1));
      chk_log1("min", DATA_W'(1));

      // average
      for (int k = 0; k < GROUP; k++) send_ds('1, 3, c);
`ifdef IOTDF_AVG_EN
      chk_log1("avg_ones", '1);
`else
      chk_log0("avg_off_ones");
`endif
      send_ramp(3, DATA_W'(1), c0);
`ifdef IOTDF_AVG_EN
      chk_log1("avg_ramp", DATA_W'(4));
`else
      chk_log0("avg_off_ramp");
`endif

      // range extract / exclude with equality at both bounds
      lo_bound = DATA_W'(16'h10);
      hi_bound = DATA_W'(16'h20);
      send_ds(DATA_W'(8'h10), 4, c); send_ds(DATA_W'(8'h15), 4, c);
      send_ds(DATA_W'(8'h20), 4, c); send_ds(DATA_W'(8'h30), 4, c);
      chk_log1("extract", DATA_W'(8'h15));
      send_ds(DATA_W'(8'h10), 5, c); send_ds(DATA_W'(8'h15), 5, c);
      send_ds(DATA_W'(8'h20), 5, c); send_ds(DATA_W'(8'h30), 5, c);
      chk_log1("exclude", DATA_W'(8'h30));

      // peak-max over group maxima 0x50, 0x40, 0x60, then peak-min
      send_ramp(6, DATA_W'(8'h49), c0);
      send_ramp(6, DATA_W'(8'h39), c0);
      send_ramp(6, DATA_W'(8'h59), c0);
      check("pmax_count", DATA_W'(log_q.size()), DATA_W'(2));
      check("pmax_first", (log_q.size() > 0) ? log_q[0] : 'x, DATA_W'(8'h50));
      check("pmax_second", (log_q.size() > 1) ? log_q[1] : 'x, DATA_W'(8'h60));
      log_q.delete();
      send_ramp(7, DATA_W'(8'h70), c0);
      chk_log1("pmin_after_switch", DATA_W'(8'h70));

      // in_en gap mid-dataset
      gap_at = 7;
      send_ramp(1, DATA_W'(8'h20), c0);
      gap_at = -1;
      chk_log1("max_with_gap", DATA_W'(8'h27));

      // reset in the middle of a dataset
      for (int b = 0; b < 5; b++) begin
         in_en = 1; iot_in = 8'hFF; fn_sel = 3'd1;
         tick();
      end
      in_en = 0;
      #2;
      rst = 0;
      model_reset();
      #1;
      check("async_rst_valid", DATA_W'(valid), DATA_W'(0));
      check("async_rst_out", iot_out, DATA_W'(0));
      repeat (2) tick();
      rst = 1;
      log_q.delete();
      send_ramp(1, DATA_W'(1), c0);
      chk_log1("max_after_reset", DATA_W'(8));

      // randomized traffic
      gap_pct = 25;
      for (int r = 0; r < 30; r++) begin
         int fn, nds;
         fn = $urandom_range(0, 7);
         nds = $urandom_range(1, 20);
         for (int k = 0; k < nds; k++) begin
            lo_bound = DATA_W'($urandom_range(0, 60));
            hi_bound = DATA_W'($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) d = {$urandom(), $urandom(), $urandom(), $urandom()};
            else d = DATA_W'($urandom_range(0, 63));
            send_ds(d, fn, c);
         end
      end
      gap_pct = 0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
